// File: rtl/conv_pe_acc.sv
// Convolution PE: KxK (or 1x1) window over TIN channels, TOUT parallel MACs,
// shadow/active filter banks and saturating psum accumulation across tiles.
module conv_pe_acc #(
    parameter int K        = 3,
    parameter int TIN      = 4,
    parameter int TOUT     = 4,
    parameter int W_DATA   = 8,
    parameter int W_KERNEL = 8,
    parameter int W_PSUM   = 32,
    parameter int W_IDX    = 2
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           i_mode,
    input  logic                           i_data_run,
    input  logic                           i_cal_start,
    input  logic                           i_first_row,
    input  logic                           i_last_row,
    input  logic                           i_first_col,
    input  logic                           i_last_col,
    input  logic [K*TIN*W_DATA-1:0]        i_ifm,
    input  logic                           i_load_filter,
    input  logic [W_IDX-1:0]               i_load_idx,
    input  logic [TOUT*K*K*W_KERNEL-1:0]   i_filter,
    input  logic                           i_swap_filter,
    input  logic                           i_acc_first,
    input  logic                           i_acc_last,
    output logic [TOUT*W_PSUM-1:0]         o_acc,
    output logic                           o_vld
);

    localparam int KK     = K * K;
    localparam int W_PROD = W_DATA + W_KERNEL;
    localparam int W_SUM  = W_PROD + $clog2(TIN * KK);
    localparam int W_EXT  = ((W_SUM > W_PSUM) ? W_SUM : W_PSUM) + 1;

    localparam logic signed [W_EXT-1:0] EXT_MAX = {{(W_EXT-W_PSUM+1){1'b0}}, {(W_PSUM-1){1'b1}}};
    localparam logic signed [W_EXT-1:0] EXT_MIN = {{(W_EXT-W_PSUM+1){1'b1}}, {(W_PSUM-1){1'b0}}};

    logic signed [W_DATA-1:0]   win_q    [K][K][TIN];
    logic signed [W_KERNEL-1:0] shadow_q [TOUT][TIN][KK];
    logic signed [W_KERNEL-1:0] active_q [TOUT][TIN][KK];
    logic                       tap_en   [K][K];
    logic signed [W_PROD-1:0]   prod_d   [TOUT][TIN][KK];
    logic signed [W_PROD-1:0]   prod_q   [TOUT][TIN][KK];
    logic signed [W_SUM-1:0]    sum_d    [TOUT];
    logic signed [W_SUM-1:0]    sum_q    [TOUT];
    logic signed [W_EXT-1:0]    ext_d    [TOUT];
    logic signed [W_PSUM-1:0]   acc_d    [TOUT];
    logic signed [W_PSUM-1:0]   acc_q    [TOUT];
    logic signed [W_PSUM-1:0]   o_acc_q  [TOUT];
    logic v1_q, f1_q, l1_q;
    logic v2_q, f2_q, l2_q;
    logic v3_q, o_vld_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    for (int ch = 0; ch < TIN; ch++)
                        win_q[r][c][ch] <= '0;
        end else if (i_data_run || i_cal_start) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K-1; c++)
                    for (int ch = 0; ch < TIN; ch++)
                        win_q[r][c][ch] <= win_q[r][c+1][ch];
            if (i_data_run) begin
                for (int r = 0; r < K; r++)
                    for (int ch = 0; ch < TIN; ch++)
                        win_q[r][K-1][ch] <= i_ifm[(r*TIN+ch)*W_DATA +: W_DATA];
            end
        end
    end

    // Swap reads shadow before this edge's load lands, so load+swap gives the old shadow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int o = 0; o < TOUT; o++)
                for (int ch = 0; ch < TIN; ch++)
                    for (int t = 0; t < KK; t++) begin
                        shadow_q[o][ch][t] <= '0;
                        active_q[o][ch][t] <= '0;
                    end
        end else begin
            if (i_swap_filter) active_q <= shadow_q;
            if (i_load_filter) begin
                for (int o = 0; o < TOUT; o++)
                    for (int t = 0; t < KK; t++)
                        shadow_q[o][i_load_idx][t] <= i_filter[(o*KK+t)*W_KERNEL +: W_KERNEL];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) begin
                if (i_mode)
                    tap_en[r][c] = (r == K/2) && (c == K/2);
                else
                    tap_en[r][c] = !((i_first_row && r == 0) || (i_last_row && r == K-1) ||
                                     (i_first_col && c == 0) || (i_last_col && c == K-1));
            end
    end

    always_comb begin
        for (int o = 0; o < TOUT; o++)
            for (int ch = 0; ch < TIN; ch++)
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        prod_d[o][ch][r*K+c] = tap_en[r][c] ?
                            W_PROD'(win_q[r][c][ch]) * W_PROD'(active_q[o][ch][r*K+c]) : '0;
    end

    always_comb begin
        for (int o = 0; o < TOUT; o++) begin
            sum_d[o] = '0;
            for (int ch = 0; ch < TIN; ch++)
                for (int t = 0; t < KK; t++)
                    sum_d[o] = sum_d[o] + W_SUM'(prod_q[o][ch][t]);
        end
    end

    // Wide add then clamp; also covers a single-beat sum wider than W_PSUM.
    always_comb begin
        for (int o = 0; o < TOUT; o++) begin
            ext_d[o] = f2_q ? W_EXT'(sum_q[o]) : W_EXT'(acc_q[o]) + W_EXT'(sum_q[o]);
            if (ext_d[o] > EXT_MAX)
                acc_d[o] = W_PSUM'(EXT_MAX);
            else if (ext_d[o] < EXT_MIN)
                acc_d[o] = W_PSUM'(EXT_MIN);
            else
                acc_d[o] = W_PSUM'(ext_d[o]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int o = 0; o < TOUT; o++) begin
                for (int ch = 0; ch < TIN; ch++)
                    for (int t = 0; t < KK; t++)
                        prod_q[o][ch][t] <= '0;
                sum_q[o]   <= '0;
                acc_q[o]   <= '0;
                o_acc_q[o] <= '0;
            end
            v1_q    <= 1'b0;
            f1_q    <= 1'b0;
            l1_q    <= 1'b0;
            v2_q    <= 1'b0;
            f2_q    <= 1'b0;
            l2_q    <= 1'b0;
            v3_q    <= 1'b0;
            o_vld_q <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            v1_q    <= i_cal_start;
            f1_q    <= i_cal_start & i_acc_first;
            l1_q    <= i_cal_start & i_acc_last;
            sum_q   <= sum_d;
            v2_q    <= v1_q;
            f2_q    <= f1_q;
            l2_q    <= l1_q;
            if (v2_q) acc_q <= acc_d;
            v3_q    <= v2_q & l2_q;
            o_vld_q <= v3_q;
            if (v3_q) o_acc_q <= acc_q;
        end
    end

    genvar g;
    for (g = 0; g < TOUT; g++) begin : g_out
        assign o_acc[g*W_PSUM +: W_PSUM] = o_acc_q[g];
    end
    assign o_vld = o_vld_q;

endmodule

// File: tb/tb_conv_pe_acc.sv
// Bench for conv_pe_acc: directed cases plus randomized groups against an
// arithmetic reference model; a second instance runs with 16-bit psums.
module tb_conv_pe_acc;

    localparam int K    = 3;
    localparam int TIN  = 4;
    localparam int TOUT = 4;
    localparam int WD   = 8;
    localparam int WK   = 8;
    localparam int WP   = 32;
    localparam int WP16 = 16;
    localparam int WI   = 2;
    localparam int KK   = K * K;
    localparam int CTR  = (K/2)*K + K/2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic i_mode = 0, i_data_run = 0, i_cal_start = 0;
    logic i_first_row = 0, i_last_row = 0, i_first_col = 0, i_last_col = 0;
    logic [K*TIN*WD-1:0] i_ifm = '0;
    logic i_load_filter = 0;
    logic [WI-1:0] i_load_idx = '0;
    logic [TOUT*KK*WK-1:0] i_filter = '0;
    logic i_swap_filter = 0, i_acc_first = 0, i_acc_last = 0;
    logic [TOUT*WP-1:0]   o_acc32;
    logic [TOUT*WP16-1:0] o_acc16;
    logic vld32, vld16;

    always #5 clk = ~clk;

    conv_pe_acc #(.K(K), .TIN(TIN), .TOUT(TOUT), .W_DATA(WD), .W_KERNEL(WK), .W_PSUM(WP), .W_IDX(WI)) u_dut (
        .clk(clk), .rstn(rstn), .i_mode(i_mode), .i_data_run(i_data_run), .i_cal_start(i_cal_start),
        .i_first_row(i_first_row), .i_last_row(i_last_row), .i_first_col(i_first_col), .i_last_col(i_last_col),
        .i_ifm(i_ifm), .i_load_filter(i_load_filter), .i_load_idx(i_load_idx), .i_filter(i_filter),
        .i_swap_filter(i_swap_filter), .i_acc_first(i_acc_first), .i_acc_last(i_acc_last),
        .o_acc(o_acc32), .o_vld(vld32));

    conv_pe_acc #(.K(K), .TIN(TIN), .TOUT(TOUT), .W_DATA(WD), .W_KERNEL(WK), .W_PSUM(WP16), .W_IDX(WI)) u_sat (
        .clk(clk), .rstn(rstn), .i_mode(i_mode), .i_data_run(i_data_run), .i_cal_start(i_cal_start),
        .i_first_row(i_first_row), .i_last_row(i_last_row), .i_first_col(i_first_col), .i_last_col(i_last_col),
        .i_ifm(i_ifm), .i_load_filter(i_load_filter), .i_load_idx(i_load_idx), .i_filter(i_filter),
        .i_swap_filter(i_swap_filter), .i_acc_first(i_acc_first), .i_acc_last(i_acc_last),
        .o_acc(o_acc16), .o_vld(vld16));

    int n_tests = 0;
    int n_fail  = 0;

    int win_m    [K][K][TIN];
    int shadow_m [TOUT][TIN][KK];
    int active_m [TOUT][TIN][KK];
    longint acc32_m [TOUT];
    longint acc16_m [TOUT];
    int colv [K][TIN];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint lane32(input int o);
        return longint'($signed(o_acc32[o*WP +: WP]));
    endfunction

    function automatic longint lane16(input int o);
        return longint'($signed(o_acc16[o*WP16 +: WP16]));
    endfunction

    function automatic longint clampw(input longint v, input int w);
        longint mx, mn;
        mx = (longint'(1) << (w-1)) - 1;
        mn = -mx - 1;
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    // Dot product of the visible window with the active filter of output channel o.
    function automatic longint ref_sum(input int o, input bit md, input bit fr, input bit lr,
                                       input bit fc, input bit lc);
        longint s = 0;
        bit use_tap;
        for (int ch = 0; ch < TIN; ch++)
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) begin
                    if (md) use_tap = (r == K/2) && (c == K/2);
                    else use_tap = !(fr && r == 0) && !(lr && r == K-1) && !(fc && c == 0) && !(lc && c == K-1);
                    if (use_tap) s += longint'(win_m[r][c][ch]) * longint'(active_m[o][ch][r*K+c]);
                end
        return s;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < TOUT; o++) begin
            acc32_m[o] = 0;
            acc16_m[o] = 0;
            for (int ch = 0; ch < TIN; ch++)
                for (int t = 0; t < KK; t++) begin
                    shadow_m[o][ch][t] = 0;
                    active_m[o][ch][t] = 0;
                end
        end
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                for (int ch = 0; ch < TIN; ch++)
                    win_m[r][c][ch] = 0;
    endtask

    task automatic push();
        @(negedge clk);
        i_data_run = 1;
        for (int r = 0; r < K; r++)
            for (int ch = 0; ch < TIN; ch++) begin
                i_ifm[(r*TIN+ch)*WD +: WD] = colv[r][ch][WD-1:0];
                for (int c = 0; c < K-1; c++) win_m[r][c][ch] = win_m[r][c+1][ch];
                win_m[r][K-1][ch] = colv[r][ch];
            end
        @(posedge clk);
        #1 i_data_run = 0;
    endtask

    task automatic fill(input int v);
        for (int r = 0; r < K; r++)
            for (int ch = 0; ch < TIN; ch++) colv[r][ch] = v;
        repeat (K) push();
    endtask

    task automatic rand_col();
        for (int r = 0; r < K; r++)
            for (int ch = 0; ch < TIN; ch++) colv[r][ch] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic load_slot(input int idx, input bit rnd, input int val, input int cval, input bit swp);
        int tmp [TOUT][KK];
        int w;
        @(negedge clk);
        for (int o = 0; o < TOUT; o++)
            for (int t = 0; t < KK; t++) begin
                w = rnd ? int'($urandom_range(0, 255)) - 128 : ((t == CTR) ? cval : val);
                tmp[o][t] = w;
                i_filter[(o*KK+t)*WK +: WK] = w[WK-1:0];
            end
        i_load_filter = 1;
        i_load_idx    = WI'(idx);
        i_swap_filter = swp;
        if (swp) active_m = shadow_m;
        for (int o = 0; o < TOUT; o++)
            for (int t = 0; t < KK; t++) shadow_m[o][idx][t] = tmp[o][t];
        @(posedge clk);
        #1;
        i_load_filter = 0;
        i_swap_filter = 0;
    endtask

    task automatic load_all(input int val, input int cval);
        for (int s = 0; s < TIN; s++) load_slot(s, 0, val, cval, 0);
        @(negedge clk);
        i_swap_filter = 1;
        active_m = shadow_m;
        @(posedge clk);
        #1 i_swap_filter = 0;
    endtask

    task automatic cal(input bit md, input bit fr, input bit lr, input bit fc, input bit lc,
                       input bit first, input bit last, input bit swp);
        longint s;
        @(negedge clk);
        i_cal_start = 1; i_mode = md;
        i_first_row = fr; i_last_row = lr; i_first_col = fc; i_last_col = lc;
        i_acc_first = first; i_acc_last = last; i_swap_filter = swp;
        for (int o = 0; o < TOUT; o++) begin
            s = ref_sum(o, md, fr, lr, fc, lc);
            acc32_m[o] = first ? clampw(s, WP)   : clampw(acc32_m[o] + s, WP);
            acc16_m[o] = first ? clampw(s, WP16) : clampw(acc16_m[o] + s, WP16);
        end
        if (swp) active_m = shadow_m;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K-1; c++)
                for (int ch = 0; ch < TIN; ch++) win_m[r][c][ch] = win_m[r][c+1][ch];
        @(posedge clk);
        #1;
        i_cal_start = 0; i_mode = 0;
        i_first_row = 0; i_last_row = 0; i_first_col = 0; i_last_col = 0;
        i_acc_first = 0; i_acc_last = 0; i_swap_filter = 0;
    endtask

    // Waits (bounded) for the group result; latency counted in negedges after the last beat's edge.
    task automatic expect_result(input string tag);
        int lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (vld32) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, lat, 4);
        if (lat != 0) begin
            chk({tag, "_vld16"}, longint'(vld16), 1);
            for (int o = 0; o < TOUT; o++) begin
                chk($sformatf("%s_acc32_l%0d", tag, o), lane32(o), acc32_m[o]);
                chk($sformatf("%s_acc16_l%0d", tag, o), lane16(o), acc16_m[o]);
            end
            @(negedge clk);
            chk({tag, "_pulse"}, longint'(vld32), 0);
        end
    endtask

    task automatic chk_const(input string tag, input longint v32, input longint v16);
        for (int o = 0; o < TOUT; o++) begin
            chk($sformatf("%s_c32_l%0d", tag, o), lane32(o), v32);
            chk($sformatf("%s_c16_l%0d", tag, o), lane16(o), v16);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_vld32", longint'(vld32), 0);
        chk("rst_vld16", longint'(vld16), 0);
        chk_const("rst", 0, 0);
        rstn = 1;

        // Two beats in flight when reset hits: they must vanish.
        load_all(1, 1);
        fill(1);
        cal(0, 0, 0, 0, 0, 1, 1, 0);
        cal(0, 0, 0, 0, 0, 1, 1, 0);
        rstn = 0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            chk("midrst_vld", longint'(vld32), 0);
        end
        rstn = 1;
        repeat (8) begin
            @(negedge clk);
            chk("postrst_vld32", longint'(vld32), 0);
            chk("postrst_vld16", longint'(vld16), 0);
        end
        chk_const("postrst", 0, 0);

        load_all(1, 1);
        fill(1);
        cal(0, 0, 0, 0, 0, 1, 1, 0);
        expect_result("k3");
        chk_const("k3", 36, 36);
        cal(0, 1, 0, 1, 0, 1, 1, 0);
        expect_result("pad2");
        chk_const("pad2", 16, 16);
        cal(0, 1, 1, 1, 1, 1, 1, 0);
        expect_result("pad4");
        chk_const("pad4", 4, 4);

        load_all(5, -2);
        for (int p = 0; p < 2; p++) begin
            fill(100);
            for (int ch = 0; ch < TIN; ch++) colv[K/2][ch] = 3;
            for (int r = 0; r < K; r++)
                for (int ch = 0; ch < TIN; ch++)
                    if (r != K/2) colv[r][ch] = 100;
            // Re-push so the centre column holds the 3s.
            for (int r = 0; r < K; r++)
                for (int ch = 0; ch < TIN; ch++) win_m[r][0][ch] = win_m[r][0][ch];
            push();
            fill(100);
            for (int ch = 0; ch < TIN; ch++) colv[K/2][ch] = 3;
            for (int r = 0; r < K; r++)
                for (int ch = 0; ch < TIN; ch++) colv[r][ch] = (r == K/2) ? 3 : 100;
            for (int r = 0; r < K; r++)
                for (int ch = 0; ch < TIN; ch++) colv[r][ch] = 100;
            push();
            for (int r = 0; r < K; r++)
                for (int ch = 0; ch < TIN; ch++) colv[r][ch] = (r == K/2) ? 3 : 100;
            push();
            for (int r = 0; r < K; r++)
                for (int ch = 0; ch < TIN; ch++) colv[r][ch] = 100;
            push();
            chk($sformatf("m1_win%0d", p), longint'(win_m[K/2][K/2][0]), 3);
            cal(1, p[0], p[0], p[0], p[0], 1, 1, 0);
            expect_result($sformatf("m1_%0d", p));
            chk_const($sformatf("m1_%0d", p), -24, -24);
        end

        load_all(1, 1);
        fill(1);
        cal(0, 0, 0, 0, 0, 1, 0, 0);
        cal(0, 0, 0, 0, 0, 0, 0, 0);
        cal(0, 0, 0, 0, 0, 0, 1, 0);
        expect_result("acc3");
        chk_const("acc3", 108, 108);
        cal(0, 0, 0, 0, 0, 1, 1, 0);
        expect_result("acc_new");
        chk_const("acc_new", 36, 36);

        load_slot(0, 0, 2, 2, 1);
        cal(0, 0, 0, 0, 0, 1, 1, 0);
        expect_result("ldswp_old");
        chk_const("ldswp_old", 36, 36);
        @(negedge clk);
        i_swap_filter = 1;
        active_m = shadow_m;
        @(posedge clk);
        #1 i_swap_filter = 0;
        cal(0, 0, 0, 0, 0, 1, 1, 0);
        expect_result("ldswp_new");
        chk_const("ldswp_new", 45, 45);
        load_slot(0, 0, 1, 1, 0);
        cal(0, 0, 0, 0, 0, 1, 1, 1);
        expect_result("calswp_old");
        chk_const("calswp_old", 45, 45);
        cal(0, 0, 0, 0, 0, 1, 1, 0);
        expect_result("calswp_new");
        chk_const("calswp_new", 36, 36);

        load_all(127, 127);
        fill(127);
        cal(0, 0, 0, 0, 0, 1, 1, 0);
        expect_result("sat1");
        chk_const("sat1", 580644, 32767);
        cal(0, 0, 0, 0, 0, 1, 0, 0);
        cal(0, 0, 0, 0, 0, 0, 1, 0);
        expect_result("sat2");
        chk_const("sat2", 1161288, 32767);
        fill(-128);
        cal(0, 0, 0, 0, 0, 1, 1, 0);
        expect_result("satneg");
        chk_const("satneg", -585216, -32768);

        for (int s = 0; s < TIN; s++) load_slot(s, 1, 0, 0, (s == TIN-1));
        for (int i = 0; i < K; i++) begin
            rand_col();
            push();
        end
        for (int g = 0; g < 16; g++) begin
            int len;
            len = int'($urandom_range(1, 3));
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 1) == 1) begin
                    rand_col();
                    push();
                end
                if ($urandom_range(0, 3) == 0)
                    load_slot(int'($urandom_range(0, TIN-1)), 1, 0, 0, $urandom_range(0, 1) == 1);
                cal($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    b == 0, b == len-1, $urandom_range(0, 4) == 0);
            end
            expect_result($sformatf("rnd%0d", g));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
